multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//   Multicycle signed 32-bit multiply/divide unit beside the single-cycle ALU
//   in the execute stage. A one-cycle ctrl_MULT/ctrl_DIV pulse starts the operation.
//   The unit pulses data_resultRDY when the result is valid, and the pipeline stalls
//   until then. Results and exceptions use the same conventions as ALU add/sub.
// PARAMETERS
//   WIDTH    32   operand/result width; only 32 is supported and verified
//   ITERS    32   iterations per operation; must equal WIDTH
// PORTS
//   clock            in   1   rising-edge clock
//   reset            in   1   asynchronous, active-high reset
//   data_operandA    in   32  multiplicand / dividend, sampled on start edge only
//   data_operandB    in   32  multiplier / divisor, sampled on start edge only
//   ctrl_MULT        in   1   start-multiply pulse
//   ctrl_DIV         in   1   start-divide pulse
//   data_result      out  32  product low word / quotient; held until next start
//   data_exception   out  1   overflow or divide-by-zero; held with data_result
//   data_resultRDY   out  1   one-cycle pulse: result/exception valid this cycle
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-operation):
//     - FSM returns to IDLE.
//     - data_result=0, data_exception=0, data_resultRDY=0; counter and regs cleared.
//   - FSM has three states:
//     - IDLE -> RUN on a start pulse.
//     - RUN does one iteration per clock and goes to DONE after ITERS iterations.
//     - DONE drives RDY=1 for exactly one cycle, then goes to IDLE.
//   - Latency: start is sampled at edge E0. Iterations run on E1..E32, and outputs
//     register at E33. RDY is high from E33 to E34, a fixed 33 cycles for both ops.
//   - Start pulse in any state, including RUN and DONE:
//     - Aborts any operation in progress; no RDY is issued for the aborted op.
//     - Relatches operands and restarts from E0.
//   - ctrl_MULT and ctrl_DIV high together: MULT wins and DIV is ignored.
//   - Operand changes after the start edge have no effect.
//   - Multiply:
//     - Shift-add over |A|,|B| into a 64-bit product; negate if sign(A)^sign(B).
//     - data_result = product[31:0].
//     - data_exception=1 iff product[63:31] is not all-0 or all-1, i.e. the
//       product does not fit in 32-bit signed.
//   - Divide: restoring division of |A| by |B|.
//     - Quotient is truncated toward zero, then negated if sign(A)^sign(B).
//     - Remainder is discarded.
//     - B==0: data_result=0, data_exception=1. Still takes the full 33 cycles.
//     - A=0x80000000 and B=0xFFFFFFFF: data_result=0x80000000, exception=1.
//     - |0x80000000| is handled as unsigned 2^31 internally, with no intermediate
//       overflow.
//   - data_result and data_exception change only on the DONE-entry edge or on reset.
//     They stay stable across IDLE and across a restarted RUN.
// STRUCTURE
//   - Shared header multdiv_defs.vh holds:
//     - WIDTH and ITERS.
//     - FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//     - DIV_OVF_RESULT = 32'h80000000.
//   - One sub-module, multdiv_counter: 5-bit down counter with load and terminal
//     flag, async active-high reset.
//   - The iteration add/subtract and the final sign negation reuse the existing
//     thirty_two_bit_cla.
// TESTING
//   1. MULT A=7, B=-3 -> RDY exactly 33 cycles after start; result=0xFFFFFFEB, exc=0.
//   2. MULT A=0x00010000, B=0x00010000 -> result=0, exc=1.
//      MULT A=0x40000000, B=2 -> result=0x80000000, exc=1.
//   3. DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exc=0.
//      DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exc=1.
//   4. DIV A=5, B=0 -> RDY after 33 cycles; result=0, exc=1.
//   5. DIV A=100, B=7, new MULT A=6, B=6 pulsed 10 cycles later -> single RDY
//      33 cycles after the second pulse; result=36, no RDY for the aborted divide.
//   6. Reset asserted asynchronously mid-RUN (between edges) -> outputs 0 immediately;
//      no RDY after release. MULT+DIV pulsed together -> multiply result.

Source files
------------

// File: rtl/multdiv_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the multicycle multiply/divide unit.
package multdiv_unit_pkg;
    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] DIV_OVF_RESULT = 32'h80000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 0x80000000 maps to unsigned 2^31, which still fits in 32 bits.
    function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 32'd1) : x;
    endfunction
endpackage

// File: rtl/multdiv_counter.sv
// Iteration down counter with synchronous load and terminal-count flag.
import multdiv_unit_pkg::*;

module multdiv_counter (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign tc = (count_q == '0);
endmodule

// File: rtl/thirty_two_bit_cla.sv
// 32-bit adder with carry in/out shared by the iteration step and final negation.
module thirty_two_bit_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiply (shift-add) / divide (restoring) unit, fixed 33-cycle latency.
import multdiv_unit_pkg::*;

module multdiv_unit (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0] hi_q, hi_d;      // product high word / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;      // multiplier->product low / dividend->quotient
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             fin_q, fin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start, cnt_load, cnt_dec, cnt_tc;
    logic [WIDTH-1:0] cla_a, cla_b, cla_sum, shifted;
    logic             cla_cin, cla_cout;
    logic [WIDTH-1:0] fin_res;
    logic             fin_exc;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

    // One adder: iteration step while running, two's-complement of lo on the finishing cycle.
    always_comb begin
        cla_a   = hi_q;
        cla_b   = lo_q[0] ? mc_q : '0;
        cla_cin = 1'b0;
        if (fin_q) begin
            cla_a   = ~lo_q;
            cla_b   = '0;
            cla_cin = 1'b1;
        end else if (div_q) begin
            cla_a   = shifted;
            cla_b   = ~mc_q;
            cla_cin = 1'b1;
        end
    end

    thirty_two_bit_cla u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    multdiv_counter u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // Overflow judged on the magnitude: negatives may reach 2^31, positives only 2^31-1.
    always_comb begin
        fin_res = neg_q ? cla_sum : lo_q;
        fin_exc = 1'b0;
        if (!div_q) begin
            if (neg_q)
                fin_exc = (hi_q != '0) || (lo_q[WIDTH-1] && (lo_q[WIDTH-2:0] != '0));
            else
                fin_exc = (hi_q != '0) || lo_q[WIDTH-1];
        end else if (dz_q) begin
            fin_res = '0;
            fin_exc = 1'b1;
        end else if (!neg_q && lo_q[WIDTH-1]) begin
            fin_res = DIV_OVF_RESULT;
            fin_exc = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_d    = div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        fin_d    = fin_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (start) begin
            state_d  = S_RUN;
            div_d    = !ctrl_MULT;
            mc_d     = abs32(data_operandB);
            hi_d     = '0;
            lo_d     = abs32(data_operandA);
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = (data_operandB == '0);
            fin_d    = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (fin_q) begin
                        result_d = fin_res;
                        exc_d    = fin_exc;
                        rdy_d    = 1'b1;
                        fin_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_dec = !cnt_tc;
                        fin_d   = cnt_tc;
                        if (div_q) begin
                            hi_d = cla_cout ? cla_sum : shifted;
                            lo_d = {lo_q[WIDTH-2:0], cla_cout};
                        end else begin
                            hi_d = {cla_cout, cla_sum[WIDTH-1:1]};
                            lo_d = {cla_sum[0], lo_q[WIDTH-1:1]};
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mc_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            fin_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_q     <= mc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            fin_q    <= fin_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed table-driven bench for multdiv_unit plus abort and async-reset sequences.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    int n_cmp = 0;
    int n_bad = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse start so the sampling edge is E0; scramble operands right after it.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 45);
    endtask

    initial begin
        int n;
        int rdy_cnt;
        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h40000000, 32'd2,        32'h80000000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'd3,        32'd4,        32'd12,       1'b0};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
            wait_rdy(n);
            chk($sformatf("v%0d_latency", i), n, 32'd33);
            chk($sformatf("v%0d_result", i), data_result, vecs[i].res);
            chk($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
            repeat (3) @(posedge clock);
            #1;
            chk($sformatf("v%0d_rdy_drop", i), {31'd0, data_resultRDY}, 32'd0);
            chk($sformatf("v%0d_hold", i), data_result, vecs[i].res);
        end

        // Abort: divide restarted by a multiply 10 cycles later; the divide never reports.
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        rdy_cnt = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        chk("abort_held_result", data_result, 32'd12);
        start_op(1'b1, 1'b0, 32'd6, 32'd6);
        chk("abort_early_rdy", rdy_cnt, 32'd0);
        wait_rdy(n);
        chk("abort_latency", n, 32'd33);
        chk("abort_result", data_result, 32'd36);
        chk("abort_exc", {31'd0, data_exception}, 32'd0);

        // Async reset between edges, mid-run.
        start_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'd9);
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_result", data_result, 32'd0);
        chk("arst_exc", {31'd0, data_exception}, 32'd0);
        chk("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        chk("arst_no_rdy", rdy_cnt, 32'd0);
        chk("arst_result_held", data_result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
